// File: rtl/mem_arbiter.sv
// Purpose: round-robin sequencer for two cache ports sharing one single-ported memory; loads are 8-word line bursts, stores are single words.
// Latency: load grant 1 cycle after request, beats 0..7 on cycles 2..9, done on cycle 9; store write on cycle 1, done on cycle 2.
// Backpressure: none; one transaction at a time, and requests are only looked at in IDLE, so a losing port simply keeps requesting.
module mem_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [2:0]        rbeat,
    output logic              done0,
    output logic              done1,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    // Word-offset bits inside a line; the burst only ever walks these.
    localparam int OFF_W = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, DONE} state_t;

    state_t              state_q;
    logic                lastgnt_q;    // port that received the most recent grant
    logic                port_q;       // port owning the current transaction
    logic                gnt_q;
    logic                rvalid_q;
    logic                done_q;
    logic [OFF_W-1:0]    issue_q;      // line offset currently presented on memAddr
    logic [2:0]          rbeat_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic                any_req_d;
    logic                win_d;
    logic                win_we_d;
    logic [ADDR_W-1:0]   win_addr_d;
    logic [DATA_W-1:0]   win_wdata_d;
    logic [OFF_W-1:0]    issue_d;

    // Address bits above the memory size alias away by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{addr0[31:ADDR_W], addr1[31:ADDR_W]};

    // Round-robin pick: on a tie the port that did not win last time goes next.
    always_comb begin
        any_req_d   = req0 | req1;
        win_d       = (req0 && req1) ? ~lastgnt_q : req1;
        win_we_d    = win_d ? we1 : we0;
        win_addr_d  = win_d ? addr1[ADDR_W-1:0] : addr0[ADDR_W-1:0];
        win_wdata_d = win_d ? wdata1 : wdata0;
        issue_d     = issue_q + OFF_W'(1);
    end

    // Transaction FSM; every output is a register so memory timing is clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lastgnt_q   <= 1'b1;
            port_q      <= 1'b0;
            gnt_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            issue_q     <= '0;
            rbeat_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // Single-cycle strobes fall unless a state re-asserts them.
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        gnt_q       <= 1'b1;
                        port_q      <= win_d;
                        lastgnt_q   <= win_d;
                        mem_en_q    <= 1'b1;
                        mem_wdata_q <= win_wdata_d;
                        if (win_we_d) begin
                            state_q    <= WR;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= win_addr_d;
                        end else begin
                            state_q    <= RD;
                            issue_q    <= '0;
                            mem_addr_q <= {win_addr_d[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                RD: begin
                    // Data for the word issued this cycle shows up next cycle.
                    rvalid_q <= 1'b1;
                    rbeat_q  <= 3'(issue_q);
                    if (issue_q == OFF_W'(LINE_WORDS - 1)) begin
                        state_q <= RD_LAST;
                        done_q  <= 1'b1;
                    end else begin
                        mem_en_q   <= 1'b1;
                        issue_q    <= issue_d;
                        mem_addr_q <= {mem_addr_q[ADDR_W-1:OFF_W], issue_d};
                    end
                end
                RD_LAST: begin
                    state_q <= IDLE;
                    gnt_q   <= 1'b0;
                    rbeat_q <= '0;
                end
                WR: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 1'b0;
                end
            endcase
        end
    end

    // Memory strobes are masked while reset is high so a write cycle caught by reset never lands.
    assign memEn    = mem_en_q & ~reset;
    assign memWe    = mem_we_q & ~reset;
    assign memAddr  = mem_addr_q;
    assign memWdata = mem_wdata_q;

    assign gnt0    = gnt_q & ~port_q;
    assign gnt1    = gnt_q & port_q;
    assign rvalid0 = rvalid_q & ~port_q;
    assign rvalid1 = rvalid_q & port_q;
    assign done0   = done_q & ~port_q;
    assign done1   = done_q & port_q;
    assign rbeat   = rbeat_q;
    assign rdata   = memRdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, done0, done1, memEn, memWe;
    logic [31:0] rdata, memWdata;
    logic [31:0] memRdata = '0;
    logic [2:0]  rbeat;
    logic [10:0] memAddr;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .rbeat(rbeat), .done0(done0), .done1(done1),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory device: read data one cycle after a read strobe.
    logic [31:0] mem [2048];
    always @(posedge clk) begin
        if (memEn && memWe) mem[memAddr] = memWdata;
        if (memEn && !memWe) memRdata <= mem[memAddr];
    end

    // Reference model state.
    logic [31:0] ref_mem [2048];
    int          last_gnt = 1;
    bit          t_we [2];
    logic [31:0] t_addr [2];
    logic [31:0] t_wd [2];

    typedef struct { int port; bit load; int start; int gap; } gexp_t;
    typedef struct { int port; int beat; logic [31:0] data; int rel; } bexp_t;
    typedef struct { bit we; logic [10:0] addr; logic [31:0] data; int rel; } aexp_t;
    typedef struct { int port; int rel; } dexp_t;
    gexp_t gq[$];
    bexp_t bq[$];
    aexp_t aq[$];
    dexp_t dq[$];

    bit          mon_en = 1'b0;
    int          cur_start = 0;
    int          cur_len = -1;
    bit          gnt_prev = 1'b0;
    logic [31:0] captured [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // Expected response of one transaction, derived from the line/word rules.
    task automatic push_txn(input int p, input int start, input int gap);
        gexp_t g; bexp_t b; aexp_t a; dexp_t d;
        logic [10:0] base;
        g.port = p; g.load = !t_we[p]; g.start = start; g.gap = gap;
        gq.push_back(g);
        d.port = p;
        if (t_we[p]) begin
            a.we = 1'b1; a.addr = t_addr[p][10:0]; a.data = t_wd[p]; a.rel = 0;
            aq.push_back(a);
            ref_mem[t_addr[p][10:0]] = t_wd[p];
            d.rel = 1;
        end else begin
            base = t_addr[p][10:0] & 11'h7F8;
            for (int k = 0; k < 8; k++) begin
                a.we = 1'b0; a.addr = base + 11'(k); a.data = '0; a.rel = k;
                aq.push_back(a);
                b.port = p; b.beat = k; b.data = ref_mem[base + 11'(k)]; b.rel = k + 1;
                bq.push_back(b);
            end
            d.rel = 8;
        end
        dq.push_back(d);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a grant, beat, access or done.
    always @(negedge clk) begin : mon
        gexp_t g; bexp_t b; aexp_t a; dexp_t d;
        bit gnow;
        int rel;
        if (mon_en) begin
            gnow = gnt0 | gnt1;
            chk("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
            if (gnow && !gnt_prev) begin
                if (gq.size() == 0) flag("grant_unexpected", 64'({gnt1, gnt0}));
                else begin
                    g = gq.pop_front();
                    chk("grant_port", 64'(gnt1), 64'(g.port));
                    if (g.start >= 0) chk("grant_start_cycle", 64'(cyc), 64'(g.start));
                    if (g.gap >= 0) chk("grant_gap", 64'(cyc - cur_start), 64'(g.gap));
                    cur_start = cyc;
                    cur_len = g.load ? 9 : 2;
                end
            end
            if (!gnow && gnt_prev && cur_len >= 0) begin
                chk("grant_length", 64'(cyc - cur_start), 64'(cur_len));
                cur_len = -1;
            end
            rel = cyc - cur_start;
            if (rvalid0 | rvalid1) begin
                chk("rvalid_on_granted", 64'({(rvalid0 & ~gnt0) | (rvalid1 & ~gnt1), rvalid0 & rvalid1}), 64'd0);
                if (bq.size() == 0) flag("beat_unexpected", 64'({rdata, 5'd0, rbeat}));
                else begin
                    b = bq.pop_front();
                    chk("read_beat", {rdata, 8'(rbeat), 8'(rvalid1), 16'(rel)},
                        {b.data, 8'(b.beat), 8'(b.port), 16'(b.rel)});
                end
                captured[rbeat] = rdata;
            end
            if (memEn) begin
                if (aq.size() == 0) flag("access_unexpected", 64'({memWe, memAddr}));
                else begin
                    a = aq.pop_front();
                    chk("mem_access", {4'(memWe), 12'(memAddr), (memWe ? memWdata : 32'd0), 16'(rel)},
                        {4'(a.we), 12'(a.addr), a.data, 16'(a.rel)});
                end
            end
            if (done0 | done1) begin
                if (dq.size() == 0) flag("done_unexpected", 64'({done1, done0}));
                else begin
                    d = dq.pop_front();
                    chk("done", {8'(done1), 8'(done0 & done1), 16'(rel)}, {8'(d.port), 8'd0, 16'(d.rel)});
                end
            end
            gnt_prev = gnow;
        end
    end

    task automatic wait_sig(input int sel, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            case (sel)
                0: seen = gnt0;
                1: seen = gnt1;
                2: seen = done0;
                default: seen = done1;
            endcase
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_%s: got timeout expected event within 40 cycles", name);
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, 64'({gnt0, gnt1, rvalid0, rvalid1, done0, done1, rbeat, memEn, memWe, memAddr, memWdata}), 64'd0);
    endtask

    task automatic flush();
        gq.delete(); bq.delete(); aq.delete(); dq.delete();
        cur_len = -1;
        last_gnt = 1;
    endtask

    // One arbitration round; called at posedge+1 of an IDLE cycle.
    task automatic run_round(input bit rq0, input bit rq1, input bit w0, input bit w1,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1, input bit early);
        int ord [2];
        int n;
        t_we[0] = w0; t_we[1] = w1; t_addr[0] = a0; t_addr[1] = a1; t_wd[0] = d0; t_wd[1] = d1;
        we0 = w0; we1 = w1; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        if (rq0 && rq1) begin ord[0] = 1 - last_gnt; ord[1] = last_gnt; n = 2; end
        else begin ord[0] = rq1 ? 1 : 0; ord[1] = 0; n = 1; end
        push_txn(ord[0], cyc + 1, -1);
        last_gnt = ord[0];
        if (n == 2) begin
            push_txn(ord[1], -1, t_we[ord[0]] ? 3 : 10);
            last_gnt = ord[1];
        end
        req0 = rq0; req1 = rq1;
        for (int i = 0; i < n; i++) begin
            if (early) begin
                wait_sig(ord[i], "gnt");
                @(posedge clk); #1;
                drop(ord[i]);
            end
            wait_sig(2 + ord[i], "done");
            @(posedge clk); #1;
            drop(ord[i]);
        end
    endtask

    // Both ports held high through n loads: strict alternation, 10 cycles apart.
    task automatic hold_both(input int n, input logic [31:0] a0, input logic [31:0] a1);
        int ord [$];
        int p;
        t_we[0] = 1'b0; t_we[1] = 1'b0; t_addr[0] = a0; t_addr[1] = a1;
        we0 = 1'b0; we1 = 1'b0; addr0 = a0; addr1 = a1;
        for (int i = 0; i < n; i++) begin
            p = 1 - last_gnt;
            push_txn(p, i == 0 ? cyc + 1 : -1, i == 0 ? -1 : 10);
            last_gnt = p;
            ord.push_back(p);
        end
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < n; i++) wait_sig(2 + ord[i], "done_hold");
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        gexp_t g;
        logic [31:0] old;
        bit hit;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 32'(i);
            ref_mem[i] = 32'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_outputs");
        reset = 1'b0;
        mon_en = 1'b1;

        hold_both(4, 32'h100, 32'h208);

        run_round(1, 0, 0, 0, 32'h13, 0, 0, 0, 0);
        chk("load13_beat0", 64'(captured[0]), 64'h10);
        chk("load13_beat7", 64'(captured[7]), 64'h17);

        run_round(0, 1, 0, 1, 0, 32'h25, 0, 32'hDEADBEEF, 0);
        run_round(1, 0, 0, 0, 32'h20, 0, 0, 0, 0);
        chk("store_readback_beat5", 64'(captured[5]), 64'hDEADBEEF);

        run_round(1, 0, 0, 0, 32'h7FF, 0, 0, 0, 0);
        chk("boundary_7ff_beat0", 64'(captured[0]), 64'h7F8);
        chk("boundary_7ff_beat7", 64'(captured[7]), 64'h7FF);
        run_round(0, 1, 0, 0, 0, 32'h0000_0805, 0, 0, 0);
        chk("alias_805_beat0", 64'(captured[0]), 64'h0);
        chk("alias_805_beat7", 64'(captured[7]), 64'h7);

        run_round(1, 0, 1, 0, 32'h300, 0, 32'hCAFEF00D, 0, 1);
        run_round(0, 1, 0, 0, 0, 32'h300, 0, 0, 0);
        chk("dropped_req_store_readback", 64'(captured[0]), 64'hCAFEF00D);

        // Store whose write cycle is hit by reset.
        old = ref_mem[11'h155];
        we0 = 1'b1; addr0 = 32'h155; wdata0 = 32'h1234_5678;
        g.port = 0; g.load = 1'b0; g.start = cyc + 1; g.gap = -1;
        gq.push_back(g);
        req0 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; req0 = 1'b0;
        #3;
        chk("memwe_masked_by_reset", 64'(memWe), 64'd0);
        @(posedge clk); #1;
        chk_reset_outputs("reset_in_wr_outputs");
        chk("no_write_under_reset", 64'(mem[11'h155]), 64'(old));
        flush();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during the beat-3 cycle of a burst.
        t_we[0] = 1'b0; t_addr[0] = 32'h40;
        we0 = 1'b0; addr0 = 32'h40;
        push_txn(0, cyc + 1, -1);
        last_gnt = 0;
        req0 = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(posedge clk); #1;
            hit = rvalid0 && (rbeat == 3'd3);
        end
        chk("reached_beat3", 64'(hit), 64'd1);
        reset = 1'b1; req0 = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("reset_midburst_outputs");
        flush();
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        run_round(1, 1, 0, 0, 32'h48, 32'h51, 0, 0, 0);

        for (int r = 0; r < 80; r++) begin
            int          pat;
            bit          w [2];
            logic [31:0] a [2];
            logic [31:0] d [2];
            pat = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++) begin
                w[p] = 1'($urandom_range(0, 1));
                d[p] = $urandom;
                case ($urandom_range(0, 5))
                    0: a[p] = 32'h7FF;
                    1: a[p] = 32'h805;
                    2: a[p] = $urandom | 32'h0000_07F8;
                    default: a[p] = $urandom;
                endcase
            end
            run_round(pat[0], pat[1], w[0], w[1], a[0], a[1], d[0], d[1], $urandom_range(0, 3) == 0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(gq.size() + bq.size() + aq.size() + dq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
